// File: rtl/serial_subtractor_4bit.sv
// Bit-serial 4-bit subtractor: one full-subtractor cell, LSB first, four SHIFT cycles per operation.
// The registered results Diff/Bout/Zero/Ovf update once per operation, on the edge that enters FIN.
module serial_subtractor_4bit (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [3:0] Diff,
    output logic       Bout,
    output logic       Zero,
    output logic       Ovf,
    output logic       busy,
    output logic       done,
    output logic [1:0] state_dbg
);

    // Handshake: start is sampled only in IDLE (ignored, not queued, otherwise);
    // busy covers SHIFT and FIN; done is a one-cycle pulse in FIN, when results are valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIN   = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] a_sh_q, b_sh_q;
    logic [3:0] res_q, res_d;
    logic       bw_q, bw_d;
    logic [1:0] cnt_q;
    logic [3:0] diff_q;
    logic       bout_q, zero_q, ovf_q;
    logic       a_bit, b_bit, d_bit;

    assign a_bit = a_sh_q[0];
    assign b_bit = b_sh_q[0];
    assign d_bit = a_bit ^ b_bit ^ bw_q;
    assign bw_d  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & bw_q);
    assign res_d = {d_bit, res_q[3:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        busy    = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) state_d = SHIFT;
            end
            SHIFT: begin
                busy = 1'b1;
                if (cnt_q == 2'd3) state_d = FIN;
            end
            FIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Operand registers rotate rather than shift, so on the last SHIFT cycle bit 0
    // holds the captured MSB needed for the overflow flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sh_q <= 4'd0;
            b_sh_q <= 4'd0;
            res_q  <= 4'd0;
            bw_q   <= 1'b0;
            cnt_q  <= 2'd0;
            diff_q <= 4'd0;
            bout_q <= 1'b0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        a_sh_q <= A;
                        b_sh_q <= B;
                        res_q  <= 4'd0;
                        bw_q   <= 1'b0;
                        cnt_q  <= 2'd0;
                    end
                end
                SHIFT: begin
                    a_sh_q <= {a_sh_q[0], a_sh_q[3:1]};
                    b_sh_q <= {b_sh_q[0], b_sh_q[3:1]};
                    res_q  <= res_d;
                    bw_q   <= bw_d;
                    cnt_q  <= cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        diff_q <= res_d;
                        bout_q <= bw_d;
                        zero_q <= (res_d == 4'd0);
                        ovf_q  <= (a_bit ^ b_bit) & (a_bit ^ d_bit);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Diff      = diff_q;
    assign Bout      = bout_q;
    assign Zero      = zero_q;
    assign Ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule

// File: tb/tb_serial_subtractor_4bit.sv
// Bench for serial_subtractor_4bit: directed cases, abort by reset, back-to-back starts,
// exhaustive A/B sweep and random operations against an arithmetic reference model.
module tb_serial_subtractor_4bit;
  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [3:0] A, B;
  logic [3:0] Diff;
  logic       Bout, Zero, Ovf, busy, done;
  logic [1:0] state_dbg;

  int         total = 0;
  int         bad = 0;
  logic [6:0] exp_q[$];
  logic [6:0] mon_e;

  serial_subtractor_4bit dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Diff(Diff), .Bout(Bout), .Zero(Zero), .Ovf(Ovf),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference model: {Diff, Bout, Zero, Ovf}
  function automatic logic [6:0] model(input logic [3:0] a, input logic [3:0] b);
    int sa, sb, r;
    logic [3:0] d;
    sa = (a > 4'd7) ? int'(a) - 16 : int'(a);
    sb = (b > 4'd7) ? int'(b) - 16 : int'(b);
    r  = sa - sb;
    d  = 4'((int'(a) - int'(b)) & 15);
    return {d, (a < b), (d == 4'd0), (r < -8 || r > 7)};
  endfunction

  // scoreboard: every done pulse must match the oldest expected result
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", 8'd1, 8'd0);
      end else begin
        mon_e = exp_q.pop_front();
        check("result", {1'b0, Diff, Bout, Zero, Ovf}, {1'b0, mon_e});
      end
    end
  end

  // driver: one operation; poke raises a second start mid-operation that must be ignored
  task automatic do_op(input logic [3:0] a, input logic [3:0] b, input bit poke);
    logic [6:0] prev;
    int k;
    @(posedge clk); #1;
    A = a; B = b; start = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk); #1;
    start = 1'b0;
    A = 4'($urandom); B = 4'($urandom);
    prev = {Diff, Bout, Zero, Ovf};
    k = 0;
    do begin
      @(negedge clk);
      k++;
      if (poke && k == 2) begin start = 1'b1; A = 4'd1; B = 4'd2; end
      if (poke && k == 3) start = 1'b0;
      if (!done && k <= 4) begin
        check("busy_shift", {7'd0, busy}, 8'd1);
        check("hold_shift", {1'b0, Diff, Bout, Zero, Ovf}, {1'b0, prev});
      end
    end while (!done && k < 12);
    check("latency", 8'(k), 8'd5);
    check("busy_fin", {7'd0, busy}, 8'd1);
    @(negedge clk);
    check("busy_idle", {7'd0, busy}, 8'd0);
    check("done_pulse", {7'd0, done}, 8'd0);
  endtask

  initial begin
    int cnt;
    logic [3:0] ra, rb;
    rst = 1'b1; start = 1'b0; A = 4'd0; B = 4'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_outputs", {1'b0, Diff, Bout, Zero, Ovf}, 8'd0);
    check("rst_busy", {6'd0, busy, done}, 8'd0);
    rst = 1'b0;

    // directed cases
    do_op(4'd9, 4'd4, 1'b0);
    do_op(4'd3, 4'd5, 1'b0);
    do_op(4'd7, 4'd8, 1'b0);
    do_op(4'd8, 4'd1, 1'b0);
    do_op(4'd5, 4'd5, 1'b0);
    do_op(4'd0, 4'd0, 1'b0);
    do_op(4'd9, 4'd4, 1'b1);
    check("poke_diff", {4'd0, Diff}, 8'd5);

    // reset on the second SHIFT cycle aborts the operation
    @(posedge clk); #1;
    A = 4'd9; B = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", {1'b0, Diff, Bout, Zero, Ovf}, 8'd0);
    check("abort_busy", {6'd0, busy, done}, 8'd0);
    rst = 1'b0;
    repeat (8) begin
      @(negedge clk);
      check("abort_no_done", {7'd0, done}, 8'd0);
    end
    do_op(4'd6, 4'd2, 1'b0);
    check("after_abort_diff", {4'd0, Diff}, 8'd4);

    // start held high: one result every 6 cycles
    @(posedge clk); #1;
    ra = 4'($urandom); rb = 4'($urandom);
    A = ra; B = rb; start = 1'b1;
    exp_q.push_back(model(ra, rb));
    for (int n = 0; n < 6; n++) begin
      cnt = 0;
      do begin
        @(negedge clk);
        cnt++;
      end while (!done && cnt < 20);
      check("period", 8'(cnt), 8'd6);
      if (n < 5) begin
        ra = 4'($urandom); rb = 4'($urandom);
        A = ra; B = rb;
        exp_q.push_back(model(ra, rb));
      end else begin
        start = 1'b0;
      end
    end

    // exhaustive sweep
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        do_op(4'(a), 4'(b), 1'b0);
      end
    end

    // random operations, some with an ignored mid-operation start
    for (int n = 0; n < 30; n++) begin
      do_op(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(negedge clk);
    check("queue_empty", 8'(exp_q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
